// File: rtl/victim_cache_control.sv
// victim_cache_control
//   FSM controller for a 4-entry victim cache (VC) that sits between L1 and
//   physical memory. It serves L1 miss requests in one of two ways:
//     - VC hit:  swap the hit line with the L1 victim in a single LOOKUP cycle.
//     - VC miss: write back a dirty VC victim if needed, fetch the line from
//                memory, then park the L1 victim in the freed way.
//   The block owns the VC valid/dirty bits. It drives the external LRU stack
//   through lru_load/lru_used_way, and keeps saturating hit/miss counters.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   l1_req            L1 miss needs service (held until l1_resp)
//   l1_evict_valid    L1 ejects a valid line with this request
//   l1_evict_dirty    the ejected line is dirty
//   vc_hit/vc_hit_way VC tag compare result (combinational)
//   lru_way           least-recently-used way from the LRU unit
//   pmem_resp         memory finished the current read or write
//   l1_resp           one-cycle pulse, fill data for L1 on the bus
//   l1_fill_sel       0 = fill from VC way vc_out_way, 1 = fill from memory
//   vc_out_way        VC way driven onto the VC read bus
//   vc_load           write the L1 victim into VC way vc_load_way
//   pmem_read         memory read request, held until pmem_resp
//   pmem_write        memory write request, held until pmem_resp
//   lru_load          update LRU stack, way lru_used_way becomes MRU
//   vc_valid          per-way valid bits
//   hit_count         saturating VC hit counter
//   miss_count        saturating VC miss counter
module victim_cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 l1_req,
    input  logic                 l1_evict_valid,
    input  logic                 l1_evict_dirty,
    input  logic                 vc_hit,
    input  logic [1:0]           vc_hit_way,
    input  logic [1:0]           lru_way,
    input  logic                 pmem_resp,
    output logic                 l1_resp,
    output logic                 l1_fill_sel,
    output logic [1:0]           vc_out_way,
    output logic                 vc_load,
    output logic [1:0]           vc_load_way,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 lru_load,
    output logic [1:0]           lru_used_way,
    output logic [3:0]           vc_valid,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FETCH,
        S_FILL
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           valid_q, valid_d;
    logic [3:0]           dirty_q, dirty_d;
    logic [1:0]           victim_q, victim_d;
    logic [CNT_WIDTH-1:0] hit_q, hit_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 pmem_read_q, pmem_read_d;
    logic                 pmem_write_q, pmem_write_d;

    logic                 lookup_hit;
    logic                 any_free;
    logic [1:0]           free_way;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A tag match on an invalid way is stale and must be treated as a miss.
    assign lookup_hit = vc_hit && valid_q[vc_hit_way];

    // Victim preference: the lowest-index invalid way, then the LRU way.
    always_comb begin
        any_free = ~&valid_q;
        if (!valid_q[0])      free_way = 2'd0;
        else if (!valid_q[1]) free_way = 2'd1;
        else if (!valid_q[2]) free_way = 2'd2;
        else                  free_way = 2'd3;
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        victim_d     = victim_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        l1_resp      = 1'b0;
        l1_fill_sel  = 1'b0;
        vc_out_way   = 2'd0;
        vc_load      = 1'b0;
        vc_load_way  = 2'd0;
        lru_load     = 1'b0;
        lru_used_way = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (l1_req) state_d = S_LOOKUP;
            end

            S_LOOKUP: begin
                if (lookup_hit) begin
                    // Swap: the hit line goes to L1 and the L1 victim takes its way.
                    // Without an evicted line the way is simply released.
                    l1_resp      = 1'b1;
                    vc_out_way   = vc_hit_way;
                    lru_load     = 1'b1;
                    lru_used_way = vc_hit_way;
                    hit_d        = sat_inc(hit_q);
                    if (l1_evict_valid) begin
                        vc_load              = 1'b1;
                        vc_load_way          = vc_hit_way;
                        valid_d[vc_hit_way]  = 1'b1;
                        dirty_d[vc_hit_way]  = l1_evict_dirty;
                    end else begin
                        valid_d[vc_hit_way]  = 1'b0;
                    end
                    state_d = S_IDLE;
                end else begin
                    miss_d   = sat_inc(miss_q);
                    victim_d = any_free ? free_way : lru_way;
                    // A free way is invalid by construction, so only an LRU victim
                    // can need a writeback.
                    if (!any_free && dirty_q[lru_way]) state_d = S_WRITEBACK;
                    else                               state_d = S_FETCH;
                end
            end

            S_WRITEBACK: begin
                vc_out_way = victim_q;
                if (pmem_resp) begin
                    dirty_d[victim_q] = 1'b0;
                    state_d           = S_FETCH;
                end
            end

            S_FETCH: begin
                if (pmem_resp) state_d = S_FILL;
            end

            S_FILL: begin
                l1_resp     = 1'b1;
                l1_fill_sel = 1'b1;
                if (l1_evict_valid) begin
                    vc_load           = 1'b1;
                    vc_load_way       = victim_q;
                    valid_d[victim_q] = 1'b1;
                    dirty_d[victim_q] = l1_evict_dirty;
                    lru_load          = 1'b1;
                    lru_used_way      = victim_q;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Memory strobes are registered from the next state so they are glitch
        // free and can never overlap.
        pmem_write_d = (state_d == S_WRITEBACK);
        pmem_read_d  = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            victim_q     <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            victim_q     <= victim_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign vc_valid   = valid_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule
